// File: rtl/instr_issuer.sv
// Instruction issuer: a host-fed FIFO drained into the core by a small
// IDLE/RUN/STEP/HALT sequencer. A popped 16'h0000 acts as a halt marker.
module instr_issuer #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [15:0]              in_instr,
  output logic                     in_ready,
  input  logic                     start,
  input  logic                     step,
  input  logic                     stop,
  output logic                     instr_valid,
  output logic [15:0]              instr,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              issued_count
);

  localparam int DATA_W = 16;
  localparam int AW     = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  function automatic logic is_halt_marker(input logic [DATA_W-1:0] word);
    return (word == '0);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              head_halt;
  state_t            fsm;

  assign state      = fsm;
  assign in_ready   = (fifo_count != (AW+1)'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr];
  assign head_halt  = is_halt_marker(head);

  // Only RUN and STEP drain the FIFO, and a stop command always wins over the pop.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty && !stop && (fsm == S_RUN || fsm == S_STEP))
      pop = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm          <= S_IDLE;
      instr_valid  <= 1'b0;
      instr        <= '0;
      issued_count <= '0;
    end else begin
      instr_valid <= 1'b0;
      if (pop && !head_halt) begin
        instr_valid  <= 1'b1;
        instr        <= head;
        issued_count <= issued_count + 16'd1;
      end
      case (fsm)
        S_IDLE: begin
          if (stop)       fsm <= S_IDLE;
          else if (start) fsm <= S_RUN;
          else if (step)  fsm <= S_STEP;
        end
        S_RUN: begin
          if (stop)                fsm <= S_IDLE;
          else if (pop && head_halt) fsm <= S_HALT;
        end
        S_STEP: begin
          if (stop)      fsm <= S_IDLE;
          else if (pop)  fsm <= head_halt ? S_HALT : S_IDLE;
        end
        S_HALT: begin
          if (stop)       fsm <= S_IDLE;
          else if (start) fsm <= S_RUN;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: a vector table for the basic run flow
// plus hand-written sequences for full FIFO, halt marker, stop, step and wrap.
module tb_instr_issuer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        start, step, stop;
  logic        instr_valid;
  logic [15:0] instr;
  logic [1:0]  state;
  logic [3:0]  fifo_count;
  logic [15:0] issued_count;

  int checks = 0;
  int errors = 0;

  instr_issuer #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .start(start), .step(step), .stop(stop),
    .instr_valid(instr_valid), .instr(instr), .state(state),
    .fifo_count(fifo_count), .issued_count(issued_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [15:0] iw;
    logic        st, sp, so;
    logic        ev;
    logic [15:0] ei;
    logic [1:0]  es;
    logic [3:0]  ec;
    logic        er;
    logic [15:0] eis;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_instr = 16'h0; start = 1'b0; step = 1'b0; stop = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w);
    in_valid = 1'b1; in_instr = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse(input logic s_start, input logic s_step, input logic s_stop);
    start = s_start; step = s_step; stop = s_stop;
    tick();
    start = 1'b0; step = 1'b0; stop = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'h1123, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 4'd1, 1'b1, 16'd0};
    tbl[1] = '{1'b1, 16'h2234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 4'd2, 1'b1, 16'd0};
    tbl[2] = '{1'b1, 16'h9301, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 4'd3, 1'b1, 16'd0};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 4'd3, 1'b1, 16'd0};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1123, 2'd1, 4'd2, 1'b1, 16'd1};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2234, 2'd1, 4'd1, 1'b1, 16'd2};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9301, 2'd1, 4'd0, 1'b1, 16'd3};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9301, 2'd1, 4'd0, 1'b1, 16'd3};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h9301, 2'd0, 4'd0, 1'b1, 16'd3};

    do_reset();
    check("reset_state", 32'(state), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_valid", 32'(instr_valid), 32'd0);
    check("reset_instr", 32'(instr), 32'd0);
    check("reset_issued", 32'(issued_count), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      in_valid = tbl[i].iv; in_instr = tbl[i].iw;
      start = tbl[i].st; step = tbl[i].sp; stop = tbl[i].so;
      tick();
      idle_inputs();
      check($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(tbl[i].ev));
      check($sformatf("row%0d_instr", i), 32'(instr), 32'(tbl[i].ei));
      check($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].es));
      check($sformatf("row%0d_count", i), 32'(fifo_count), 32'(tbl[i].ec));
      check($sformatf("row%0d_ready", i), 32'(in_ready), 32'(tbl[i].er));
      check($sformatf("row%0d_issued", i), 32'(issued_count), 32'(tbl[i].eis));
    end

    // Full FIFO, rejected ninth word, single step
    do_reset();
    for (int i = 0; i < 8; i++) push_word(16'h0100 + 16'(i));
    check("full_count", 32'(fifo_count), 32'd8);
    check("full_ready", 32'(in_ready), 32'd0);
    push_word(16'hDEAD);
    check("full_reject", 32'(fifo_count), 32'd8);
    pulse(1'b0, 1'b1, 1'b0);
    check("step_state", 32'(state), 32'd2);
    tick();
    check("step_valid", 32'(instr_valid), 32'd1);
    check("step_instr", 32'(instr), 32'h0100);
    check("step_count", 32'(fifo_count), 32'd7);
    check("step_ready", 32'(in_ready), 32'd1);
    check("step_idle", 32'(state), 32'd0);

    // Halt marker
    do_reset();
    push_word(16'h1111); push_word(16'h0000); push_word(16'h2222);
    pulse(1'b1, 1'b0, 1'b0);
    tick();
    check("halt_first_valid", 32'(instr_valid), 32'd1);
    check("halt_first_instr", 32'(instr), 32'h1111);
    tick();
    check("halt_marker_valid", 32'(instr_valid), 32'd0);
    check("halt_state", 32'(state), 32'd3);
    tick();
    check("halt_count", 32'(fifo_count), 32'd1);
    check("halt_hold_instr", 32'(instr), 32'h1111);
    pulse(1'b1, 1'b0, 1'b0);
    check("halt_restart", 32'(state), 32'd1);
    tick();
    check("halt_second_instr", 32'(instr), 32'h2222);
    check("halt_second_valid", 32'(instr_valid), 32'd1);
    check("halt_issued", 32'(issued_count), 32'd2);

    // Stop and start together while running
    do_reset();
    for (int i = 0; i < 4; i++) push_word(16'hA000 + 16'(i));
    pulse(1'b1, 1'b0, 1'b0);
    check("ss_run", 32'(state), 32'd1);
    check("ss_count_before", 32'(fifo_count), 32'd4);
    pulse(1'b1, 1'b0, 1'b1);
    check("ss_state", 32'(state), 32'd0);
    check("ss_count", 32'(fifo_count), 32'd4);
    check("ss_valid", 32'(instr_valid), 32'd0);

    // Step waits on an empty FIFO
    do_reset();
    pulse(1'b0, 1'b1, 1'b0);
    check("wait_state0", 32'(state), 32'd2);
    tick();
    check("wait_state1", 32'(state), 32'd2);
    push_word(16'h5555);
    check("wait_state2", 32'(state), 32'd2);
    check("wait_count", 32'(fifo_count), 32'd1);
    tick();
    check("wait_valid", 32'(instr_valid), 32'd1);
    check("wait_instr", 32'(instr), 32'h5555);
    check("wait_idle", 32'(state), 32'd0);
    tick();
    check("wait_once", 32'(instr_valid), 32'd0);
    check("wait_issued", 32'(issued_count), 32'd1);

    // Issue counter wrap and asynchronous reset mid-run
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    in_valid = 1'b1; in_instr = 16'h0001;
    for (int i = 0; i < 65536; i++) tick();
    in_valid = 1'b0;
    check("flow_count", 32'(fifo_count), 32'd1);
    tick();
    tick();
    check("wrap_issued", 32'(issued_count), 32'd0);
    check("wrap_count", 32'(fifo_count), 32'd0);
    in_valid = 1'b1; in_instr = 16'h7777;
    tick(); tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    check("areset_state", 32'(state), 32'd0);
    check("areset_count", 32'(fifo_count), 32'd0);
    check("areset_valid", 32'(instr_valid), 32'd0);
    check("areset_instr", 32'(instr), 32'd0);
    check("areset_issued", 32'(issued_count), 32'd0);
    idle_inputs();
    tick();
    reset = 1'b0;
    check("areset_ready", 32'(in_ready), 32'd1);
    tick();
    check("post_reset_valid", 32'(instr_valid), 32'd0);
    check("post_reset_state", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
